// File: rtl/cursor_gen_if.sv
// Cursor generator bus: frame sync, cursor controls, raster coordinates in; cursor pixel and blink phase out.
// master = raster/video timing side, slave = cursor_gen.
interface cursor_gen_if #(
  parameter int COL_W = 6,
  parameter int ROW_W = 5,
  parameter int CHX_W = 3,
  parameter int CHY_W = 4
);
  logic             i_vsync;
  logic             i_en;
  logic [1:0]       i_mode;
  logic             i_blink_en;
  logic [COL_W-1:0] i_wr_cell_x;
  logic [ROW_W-1:0] i_wr_cell_y;
  logic [COL_W-1:0] i_cell_x;
  logic [ROW_W-1:0] i_cell_y;
  logic [CHX_W-1:0] i_char_x;
  logic [CHY_W-1:0] i_char_y;
  logic [CHY_W-1:0] i_h;
  logic             o_cursor;
  logic             o_phase;

  modport master (
    output i_vsync, i_en, i_mode, i_blink_en,
    output i_wr_cell_x, i_wr_cell_y, i_cell_x, i_cell_y,
    output i_char_x, i_char_y, i_h,
    input  o_cursor, o_phase
  );

  modport slave (
    input  i_vsync, i_en, i_mode, i_blink_en,
    input  i_wr_cell_x, i_wr_cell_y, i_cell_x, i_cell_y,
    input  i_char_x, i_char_y, i_h,
    output o_cursor, o_phase
  );
endinterface

// File: rtl/cursor_gen.sv
// Text-mode cursor overlay: frame-counted blink, underline/block/bar shapes, one-cycle registered pixel.
// Optional macro CURSOR_MOVE_RESTART_EN restarts the blink cycle whenever the cursor cell moves.
module cursor_gen #(
  parameter int COL_W   = 6,
  parameter int ROW_W   = 5,
  parameter int CHX_W   = 3,
  parameter int CHY_W   = 4,
  parameter int BLINK_W = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  cursor_gen_if.slave bus
);

  localparam logic [CHY_W-1:0] Y_LAST = '1;

  typedef enum logic [1:0] {
    MODE_NONE      = 2'd0,
    MODE_UNDERLINE = 2'd1,
    MODE_BLOCK     = 2'd2,
    MODE_BAR       = 2'd3
  } mode_e;

  logic               vsync_q;
  logic [BLINK_W-1:0] ctr_q;
  logic [BLINK_W-1:0] ctr_d;
  logic               cursor_q;
  logic               cursor_d;

  logic               frame_edge;
  logic               move;
  logic               visible;
  logic               hit;
  logic               shape;
  logic [CHY_W-1:0]   y_thresh;
  mode_e              mode;

  assign frame_edge = bus.i_vsync & ~vsync_q;
  assign mode       = mode_e'(bus.i_mode);

`ifdef CURSOR_MOVE_RESTART_EN
  logic [COL_W-1:0] wr_x_q;
  logic [ROW_W-1:0] wr_y_q;

  assign move = (bus.i_wr_cell_x != wr_x_q) | (bus.i_wr_cell_y != wr_y_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_x_q <= '0;
      wr_y_q <= '0;
    end else if (move) begin
      wr_x_q <= bus.i_wr_cell_x;
      wr_y_q <= bus.i_wr_cell_y;
    end
  end
`else
  assign move = 1'b0;
`endif

  // A move wins over a simultaneous frame edge so the cursor starts a fresh visible half-period.
  always_comb begin
    ctr_d = ctr_q;
    if (move) begin
      ctr_d = '0;
    end else if (frame_edge) begin
      ctr_d = ctr_q + BLINK_W'(1);
    end
  end

  assign visible = bus.i_blink_en ? ~ctr_q[BLINK_W-1] : 1'b1;
  assign hit     = (bus.i_cell_x == bus.i_wr_cell_x) & (bus.i_cell_y == bus.i_wr_cell_y);

  // Underline grows upward from the bottom line: i_h = 0 is one line, all-ones fills the cell.
  assign y_thresh = Y_LAST - bus.i_h;

  always_comb begin
    shape = 1'b0;
    case (mode)
      MODE_UNDERLINE: shape = (bus.i_char_y >= y_thresh);
      MODE_BLOCK:     shape = 1'b1;
      MODE_BAR:       shape = (bus.i_char_x <= bus.i_h[CHX_W-1:0]);
      default:        shape = 1'b0;
    endcase
  end

  assign cursor_d = bus.i_en & visible & hit & shape;

  // Previous-vsync resets high so a vsync held through reset release is not counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q  <= 1'b1;
      ctr_q    <= '0;
      cursor_q <= 1'b0;
    end else begin
      vsync_q  <= bus.i_vsync;
      ctr_q    <= ctr_d;
      cursor_q <= cursor_d;
    end
  end

  assign bus.o_cursor = cursor_q;
  assign bus.o_phase  = visible;

endmodule

// File: tb/tb_cursor_gen.sv
// Directed bench for cursor_gen: shape vector table, blink sweep, move/edge priority and reset corners.
module tb_cursor_gen;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cursor_gen_if bus_if ();

  cursor_gen dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] h;
    logic [5:0] cx;
    logic [4:0] cy;
    logic [2:0] chx;
    logic [3:0] chy;
    logic       en;
    logic       exp;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [1:0] mode, input logic [3:0] h,
                              input logic [5:0] cx, input logic [4:0] cy,
                              input logic [2:0] chx, input logic [3:0] chy,
                              input logic en, input logic exp);
    vec_t v;
    v.mode = mode; v.h = h; v.cx = cx; v.cy = cy;
    v.chx = chx; v.chy = chy; v.en = en; v.exp = exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus_if.i_vsync = 1'b1;
    tick();
    bus_if.i_vsync = 1'b0;
    tick();
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic exp_phase;
    logic prev;
    vectors     = 0;
    miscompares = 0;

    // cursor cell is (3,2) for most of the run
    vecs[0]  = mk(2'd1, 4'd2,  6'd3, 5'd2, 3'd0, 4'd12, 1'b1, 1'b0);
    vecs[1]  = mk(2'd1, 4'd2,  6'd3, 5'd2, 3'd0, 4'd13, 1'b1, 1'b1);
    vecs[2]  = mk(2'd1, 4'd2,  6'd3, 5'd2, 3'd0, 4'd15, 1'b1, 1'b1);
    vecs[3]  = mk(2'd1, 4'd15, 6'd3, 5'd2, 3'd0, 4'd0,  1'b1, 1'b1);
    vecs[4]  = mk(2'd1, 4'd0,  6'd3, 5'd2, 3'd0, 4'd15, 1'b1, 1'b1);
    vecs[5]  = mk(2'd1, 4'd0,  6'd3, 5'd2, 3'd0, 4'd14, 1'b1, 1'b0);
    vecs[6]  = mk(2'd3, 4'd1,  6'd3, 5'd2, 3'd0, 4'd5,  1'b1, 1'b1);
    vecs[7]  = mk(2'd3, 4'd1,  6'd3, 5'd2, 3'd1, 4'd5,  1'b1, 1'b1);
    vecs[8]  = mk(2'd3, 4'd1,  6'd3, 5'd2, 3'd2, 4'd5,  1'b1, 1'b0);
    vecs[9]  = mk(2'd3, 4'd1,  6'd3, 5'd2, 3'd7, 4'd5,  1'b1, 1'b0);
    vecs[10] = mk(2'd3, 4'd10, 6'd3, 5'd2, 3'd2, 4'd5,  1'b1, 1'b1);
    vecs[11] = mk(2'd3, 4'd10, 6'd3, 5'd2, 3'd3, 4'd5,  1'b1, 1'b0);
    vecs[12] = mk(2'd2, 4'd0,  6'd3, 5'd2, 3'd4, 4'd7,  1'b1, 1'b1);
    vecs[13] = mk(2'd0, 4'd15, 6'd3, 5'd2, 3'd0, 4'd15, 1'b1, 1'b0);
    vecs[14] = mk(2'd2, 4'd0,  6'd4, 5'd2, 3'd0, 4'd0,  1'b1, 1'b0);
    vecs[15] = mk(2'd2, 4'd0,  6'd3, 5'd3, 3'd0, 4'd0,  1'b1, 1'b0);
    vecs[16] = mk(2'd2, 4'd0,  6'd3, 5'd2, 3'd0, 4'd0,  1'b0, 1'b0);
    vecs[17] = mk(2'd3, 4'd1,  6'd4, 5'd2, 3'd0, 4'd0,  1'b1, 1'b0);

    rst_n                = 1'b1;
    bus_if.i_vsync       = 1'b1;
    bus_if.i_en          = 1'b1;
    bus_if.i_mode        = 2'd2;
    bus_if.i_blink_en    = 1'b1;
    bus_if.i_wr_cell_x   = 6'd3;
    bus_if.i_wr_cell_y   = 5'd2;
    bus_if.i_cell_x      = 6'd3;
    bus_if.i_cell_y      = 5'd2;
    bus_if.i_char_x      = 3'd0;
    bus_if.i_char_y      = 4'd0;
    bus_if.i_h           = 4'd0;

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset_cursor", bus_if.o_cursor, 1'b0);
    check("reset_phase", bus_if.o_phase, 1'b1);
    // vsync stays high across release: no frame may be counted
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    bus_if.i_vsync = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      bus_if.i_mode   = vecs[i].mode;
      bus_if.i_h      = vecs[i].h;
      bus_if.i_cell_x = vecs[i].cx;
      bus_if.i_cell_y = vecs[i].cy;
      bus_if.i_char_x = vecs[i].chx;
      bus_if.i_char_y = vecs[i].chy;
      bus_if.i_en     = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), bus_if.o_cursor, vecs[i].exp);
    end

    // underline sweeps, also confirming the output lags the input by one cycle
    bus_if.i_mode   = 2'd1;
    bus_if.i_en     = 1'b1;
    bus_if.i_cell_x = 6'd3;
    bus_if.i_cell_y = 5'd2;
    bus_if.i_char_x = 3'd0;
    bus_if.i_char_y = 4'd0;
    bus_if.i_h      = 4'd2;
    tick();
    prev = 1'b0;
    for (int y = 0; y < 16; y++) begin
      bus_if.i_char_y = 4'(y);
      #1;
      check($sformatf("ul2_hold_y%0d", y), bus_if.o_cursor, prev);
      tick();
      prev = (y >= 13);
      check($sformatf("ul2_y%0d", y), bus_if.o_cursor, prev);
    end
    bus_if.i_h = 4'd15;
    for (int y = 0; y < 16; y++) begin
      bus_if.i_char_y = 4'(y);
      tick();
      check($sformatf("ul15_y%0d", y), bus_if.o_cursor, 1'b1);
    end

    // blink: 16 visible frames, 16 hidden, visible again at frame 32
    bus_if.i_mode = 2'd2;
    for (int f = 0; f <= 32; f++) begin
      tick();
      check($sformatf("blink_cur_f%0d", f), bus_if.o_cursor, (f % 32) < 16);
      check($sformatf("blink_ph_f%0d", f), bus_if.o_phase, (f % 32) < 16);
      if (f < 32) pulse();
    end

    for (int f = 0; f < 20; f++) pulse();
    tick();
    check("ctr20_phase", bus_if.o_phase, 1'b0);
    check("ctr20_cursor", bus_if.o_cursor, 1'b0);
    bus_if.i_blink_en = 1'b0;
    #1;
    check("steady_phase", bus_if.o_phase, 1'b1);
    tick();
    check("steady_cursor", bus_if.o_cursor, 1'b1);
    bus_if.i_blink_en = 1'b1;
    #1;
    check("blink_back_phase", bus_if.o_phase, 1'b0);
    tick();

    // cursor move coincides with a frame edge
`ifdef CURSOR_MOVE_RESTART_EN
    exp_phase = 1'b1;
`else
    exp_phase = 1'b0;
`endif
    bus_if.i_wr_cell_x = 6'd4;
    bus_if.i_vsync     = 1'b1;
    tick();
    check("move_edge_phase", bus_if.o_phase, exp_phase);
    bus_if.i_vsync = 1'b0;
    tick();
    check("move_settle_phase", bus_if.o_phase, exp_phase);
    bus_if.i_cell_x = 6'd4;
    tick();
    check("move_cursor", bus_if.o_cursor, exp_phase);

    // reset asserted mid-line clears the output without a clock edge
    bus_if.i_blink_en = 1'b0;
    tick();
    check("pre_rst_cursor", bus_if.o_cursor, 1'b1);
    @(posedge clk);
    #2;
    bus_if.i_blink_en = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_cursor", bus_if.o_cursor, 1'b0);
    check("async_rst_phase", bus_if.o_phase, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_phase", bus_if.o_phase, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cursor_gen.md
CURSOR_GEN -- requirements
Module: cursor_gen

Interface
REQ-001 Parameters SHALL be: COL_W, default 6, cell column coordinate width; ROW_W, default 5, cell row coordinate width; CHX_W, default 3, pixel-in-glyph x width; CHY_W, default 4, line-in-glyph y width; BLINK_W, default 5, frame counter width, where blink half-period = 2^(BLINK_W-1) frames.
REQ-002 i_clk  in  1  pixel clock; all state SHALL be clocked on its rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_vsync  in  1  frame sync, active-high, synchronous to i_clk.
REQ-005 i_en  in  1  cursor enable.
REQ-006 i_mode  in  2  shape: 0 none, 1 underline, 2 block, 3 bar.
REQ-007 i_blink_en  in  1  1 = blink, 0 = steady.
REQ-008 i_wr_cell_x  in  COL_W  and  i_wr_cell_y  in  ROW_W  cursor cell position.
REQ-009 i_cell_x  in  COL_W  and  i_cell_y  in  ROW_W  cell being drawn.
REQ-010 i_char_x  in  CHX_W  and  i_char_y  in  CHY_W  pixel and line inside the drawn cell.
REQ-011 i_h  in  CHY_W  underline height (0 = bottom line only, all-ones = full cell); i_h[CHX_W-1:0] = bar width minus 1.
REQ-012 o_cursor  out  1  registered cursor pixel.
REQ-013 o_phase  out  1  current blink phase, 1 = visible.

Function
REQ-014 Frame edge: a register SHALL hold the previous i_vsync; an edge SHALL be the cycle with i_vsync=1 and previous=0.
REQ-015 Frame counter ctr (BLINK_W bits) SHALL increment by 1 on each frame edge and wrap from all-ones to 0.
REQ-016 Visible phase SHALL be ~ctr[BLINK_W-1] when i_blink_en=1, and constant 1 when i_blink_en=0; o_phase SHALL equal it, with no added latency from ctr.
REQ-017 Hit SHALL be (i_cell_x==i_wr_cell_x) & (i_cell_y==i_wr_cell_y).
REQ-018 Shape: mode 1 asserts when i_char_y >= (2^CHY_W-1 - i_h), unsigned CHY_W-bit arithmetic; mode 2 asserts always; mode 3 asserts when i_char_x <= i_h[CHX_W-1:0]; mode 0 never asserts.
REQ-019 o_cursor SHALL be registered as i_en & visible & hit & shape, giving latency exactly 1 i_clk cycle from coordinate inputs.
REQ-020 i_mode, i_h, i_en and i_blink_en changes SHALL take effect on the next registered o_cursor with no glitch state; ctr SHALL keep counting while i_en=0.

Reset
REQ-021 While i_rst_n=0: ctr=0, previous-vsync register=1 (no spurious edge if i_vsync is high at release), stored position registers=0, o_cursor=0.
REQ-022 Reset assertion mid-frame SHALL clear state immediately, without waiting for i_clk; o_phase=1 during and after reset until ctr reaches 2^(BLINK_W-1).

Configuration
REQ-023 Macro CURSOR_MOVE_RESTART_EN: when defined, registers SHALL hold the last i_wr_cell_x/y, and any cycle where the inputs differ from them SHALL load ctr=0 and update the registers, so the cursor is visible for a full half-period after every move.
REQ-024 Move restart SHALL take priority over a frame edge in the same cycle (ctr=0, not 1).
REQ-025 When CURSOR_MOVE_RESTART_EN is undefined, the position registers SHALL be absent, and ctr SHALL be affected only by frame edges and reset.

Verification
REQ-026 Reset; BLINK_W=5; toggle i_vsync 16 times, then 16 more, mode 2, hit -> o_cursor=1 for frames 0-15, 0 for frames 16-31, and 1 again at frame 32.
REQ-027 Mode 1, i_h=2, hit; sweep i_char_y 0..15 -> o_cursor=1 only for i_char_y 13,14,15, each one cycle after input; i_h=15 -> all 16 lines.
REQ-028 Mode 3, i_h=1, hit -> o_cursor=1 for i_char_x 0,1 and 0 for 2..7; i_cell_x=wr+1 -> 0 for all.
REQ-029 With macro defined, ctr=20 (hidden); change i_wr_cell_x 3->4 in the same cycle as a vsync edge -> ctr=0, o_phase=1 next cycle; without macro -> ctr=21, o_phase=0.
REQ-030 Hold i_vsync=1 through reset release -> no count; i_blink_en=0 at ctr=20 -> o_phase=1; assert i_rst_n=0 mid-line -> o_cursor=0 asynchronously.
